// File: rtl/sat_stream_accumulator_pkg.sv
// Shared types and the clamping helper for the saturating stream accumulator.
package sat_stream_acc_pkg;

    typedef enum logic {ACCUM, HOLD} state_t;

    typedef struct packed {
        logic signed [63:0] value;
        logic               clamped;
    } clamp_t;

    // Clamp a sign-extended value into the two's complement range of 'width' bits.
    function automatic clamp_t sat_clamp(input logic signed [63:0] value, input int width);
        clamp_t             res;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (width - 1));
        res.value   = value;
        res.clamped = 1'b0;
        if (value > max_v) begin
            res.value   = max_v;
            res.clamped = 1'b1;
        end else if (value < min_v) begin
            res.value   = min_v;
            res.clamped = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/sat_stream_accumulator_if.sv
// Input stream, output stream and saturation flag of the block accumulator.
interface sat_stream_accumulator_if #(
    parameter int W     = 4,
    parameter int ACC_W = 8
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [W-1:0]     in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] out_data;
    logic                    out_sat;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );
endinterface

// File: rtl/sat_stream_accumulator_sat_add_w.sv
// Combinational signed saturating adder: W_SUM-bit accumulator plus W_A-bit sample.
module sat_add_w
    import sat_stream_acc_pkg::*;
#(
    parameter int W_A   = 4,
    parameter int W_SUM = 8
) (
    input  logic signed [W_SUM-1:0] a,
    input  logic signed [W_A-1:0]   b,
    output logic signed [W_SUM-1:0] sum,
    output logic                    clamped
);
    logic signed [W_SUM:0] raw;
    clamp_t                res;
    logic                  unused_hi;

    // One guard bit makes the raw sum exact before clamping.
    always_comb begin
        raw     = {a[W_SUM-1], a} + {{(W_SUM + 1 - W_A){b[W_A-1]}}, b};
        res     = sat_clamp({{(63 - W_SUM){raw[W_SUM]}}, raw}, W_SUM);
        sum     = res.value[W_SUM-1:0];
        clamped = res.clamped;
    end

    assign unused_hi = ^res.value[63:W_SUM];
endmodule

// File: rtl/sat_stream_accumulator.sv
// Block accumulator with per-step saturation and a sticky clamp flag.
// Define SAT_STREAM_ACC_OVERLAP_EN to accept the next block's first sample while retiring a result.
module sat_stream_accumulator
    import sat_stream_acc_pkg::*;
#(
    parameter int W     = 4,
    parameter int ACC_W = 8,
    parameter int N     = 8
) (
    input logic                    clk,
    input logic                    rst,
    sat_stream_accumulator_if.slave bus
);
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    state_t                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    sat_q, sat_d;
    logic                    out_valid_q, out_valid_d;
    logic signed [ACC_W-1:0] out_data_q, out_data_d;
    logic                    out_sat_q, out_sat_d;

    logic signed [ACC_W-1:0] step_sum;
    logic                    step_clamp;
    logic signed [ACC_W-1:0] sample_ext;
    logic                    last_sample;

    sat_add_w #(.W_A(W), .W_SUM(ACC_W)) u_add (
        .a       (acc_q),
        .b       (bus.in_data),
        .sum     (step_sum),
        .clamped (step_clamp)
    );

    assign sample_ext  = {{(ACC_W - W){bus.in_data[W-1]}}, bus.in_data};
    assign last_sample = (cnt_q == CNT_W'(N - 1));

`ifdef SAT_STREAM_ACC_OVERLAP_EN
    assign bus.in_ready = (state_q == ACCUM) || bus.out_ready;
`else
    assign bus.in_ready = (state_q == ACCUM);
`endif
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sat   = out_sat_q;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        sat_d       = sat_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        case (state_q)
            ACCUM: begin
                if (bus.in_valid) begin
                    acc_d = step_sum;
                    cnt_d = cnt_q + CNT_W'(1);
                    sat_d = sat_q | step_clamp;
                    if (last_sample) begin
                        out_data_d  = step_sum;
                        out_sat_d   = sat_q | step_clamp;
                        out_valid_d = 1'b1;
                        state_d     = HOLD;
                    end
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    acc_d       = '0;
                    cnt_d       = '0;
                    sat_d       = 1'b0;
                    state_d     = ACCUM;
`ifdef SAT_STREAM_ACC_OVERLAP_EN
                    // A lone sample cannot clamp because ACC_W > W.
                    if (bus.in_valid) begin
                        if (N == 1) begin
                            out_valid_d = 1'b1;
                            out_data_d  = sample_ext;
                            out_sat_d   = 1'b0;
                            state_d     = HOLD;
                        end else begin
                            acc_d = sample_ext;
                            cnt_d = CNT_W'(1);
                        end
                    end
`endif
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sat_q       <= sat_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
        end
    end

`ifndef SAT_STREAM_ACC_OVERLAP_EN
    logic unused_sample_ext;
    assign unused_sample_ext = ^sample_ext;
`endif
endmodule
